// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: sequencer for a chain of DIGITS cascaded BCD digit counters.
// Owns the counters' load, clear and per-digit enables. It builds the carry chain
// and stops the chain when the counters equal a programmable target.
// Optional feature macro: BCD_TIMER_AUTORELOAD_EN. When it is defined, DONE reloads
// preset_q and resumes RUN, which gives periodic operation.
//
// Handshake note: there is no valid/ready pairing here. Every cmd_* input is a
// single-cycle request, sampled on the rising edge of CLK and acted on at that edge.
// Requests that arrive in a state that does not accept them are dropped, so no
// request is ever held pending.
module bcd_timer_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  CLK,
    input  logic                  Clear_b,
    input  logic                  tick,
    input  logic                  cmd_start,
    input  logic                  cmd_stop,
    input  logic                  cmd_load,
    input  logic                  cmd_clear,
    input  logic [4*DIGITS-1:0]   preset,
    input  logic [4*DIGITS-1:0]   target,
    input  logic [4*DIGITS-1:0]   digit_q,
    output logic                  cnt_load,
    output logic [4*DIGITS-1:0]   cnt_data,
    output logic [DIGITS-1:0]     cnt_en,
    output logic                  cnt_clr_b,
    output logic                  running,
    output logic                  done,
    output logic                  wrap,
    output logic [2:0]            state_dbg
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CLR   = 3'd2,
        S_RUN   = 3'd3,
        S_PAUSE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   preset_q, preset_d;
    logic           cnt_clr_b_q, cnt_clr_b_d;
    logic           done_q, done_d;
    logic           wrap_q, wrap_d;
    logic           at_target;
    logic           carry_c;
`ifdef BCD_TIMER_AUTORELOAD_EN
    // Marks a LOAD that DONE started itself, so that LOAD goes on to RUN instead of IDLE.
    logic           reload_q, reload_d;
`endif

    assign at_target = (digit_q == target);

    // Carry chain: digit 0 counts on a tick in RUN, and each higher digit counts only when every digit below it is exactly 9
    always_comb begin
        cnt_en  = '0;
        carry_c = (state_q == S_RUN) && tick && !at_target;
        for (int i = 0; i < DIGITS; i++) begin
            cnt_en[i] = carry_c;
            carry_c   = carry_c && (digit_q[4*i +: 4] == 4'd9);
        end
    end

    // Next state, with command priority clear > load > stop > start
    always_comb begin
        state_d  = state_q;
        preset_d = preset_q;
`ifdef BCD_TIMER_AUTORELOAD_EN
        reload_d = 1'b0;
`endif
        unique case (state_q)
            S_IDLE, S_PAUSE: begin
                if (cmd_clear) begin
                    state_d = S_CLR;
                end else if (cmd_load) begin
                    state_d  = S_LOAD;
                    preset_d = preset;
                end else if (!cmd_stop && cmd_start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cmd_clear) begin
                    state_d = S_CLR;
                end else if (cmd_load) begin
                    state_d  = S_LOAD;
                    preset_d = preset;
                end else if (cmd_stop) begin
                    state_d = S_PAUSE;
                end else if (at_target) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (cmd_clear) begin
                    state_d = S_CLR;
                end else if (cmd_load) begin
                    state_d  = S_LOAD;
                    preset_d = preset;
`ifdef BCD_TIMER_AUTORELOAD_EN
                end else if (cmd_stop) begin
                    state_d = S_PAUSE;
                end else begin
                    state_d  = S_LOAD;
                    reload_d = 1'b1;
`endif
                end
            end
            S_LOAD: begin
                state_d = S_IDLE;
`ifdef BCD_TIMER_AUTORELOAD_EN
                if (reload_q) begin
                    if (cmd_clear) begin
                        state_d = S_CLR;
                    end else if (cmd_load) begin
                        state_d  = S_LOAD;
                        preset_d = preset;
                    end else if (cmd_stop) begin
                        state_d = S_PAUSE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
`endif
            end
            S_CLR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered strobes: the clear is low for the whole CLR cycle; done and wrap are one-cycle pulses after the event
    always_comb begin
        cnt_clr_b_d = (state_d != S_CLR);
        done_d      = (state_q == S_RUN) && (state_d == S_DONE);
        wrap_d      = cnt_en[DIGITS-1] && (digit_q[W-1 -: 4] == 4'd9);
    end

    // State and strobe registers; reset clears the counters through cnt_clr_b
    always_ff @(posedge CLK) begin
        if (!Clear_b) begin
            state_q     <= S_IDLE;
            preset_q    <= '0;
            cnt_clr_b_q <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
`ifdef BCD_TIMER_AUTORELOAD_EN
            reload_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            preset_q    <= preset_d;
            cnt_clr_b_q <= cnt_clr_b_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
`ifdef BCD_TIMER_AUTORELOAD_EN
            reload_q    <= reload_d;
`endif
        end
    end

    assign cnt_load  = (state_q == S_LOAD);
    assign cnt_data  = preset_q;
    assign cnt_clr_b = cnt_clr_b_q;
    assign running   = (state_q == S_RUN);
    assign done      = done_q;
    assign wrap      = wrap_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed testbench for bcd_timer_ctrl (DIGITS = 4). A behavioural model of the
// four BCD digit counters closes the loop through digit_q.
module tb_bcd_timer_ctrl;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CLR   = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_PAUSE = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic        clk = 1'b0;
    logic        Clear_b = 1'b0;
    logic        tick = 1'b0;
    logic        cmd_start = 1'b0, cmd_stop = 1'b0, cmd_load = 1'b0, cmd_clear = 1'b0;
    logic [15:0] preset = '0, target = 16'h9999;
    logic [15:0] digit_q = '0;
    logic        cnt_load, cnt_clr_b, running, done, wrap;
    logic [15:0] cnt_data;
    logic [3:0]  cnt_en;
    logic [2:0]  state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    bcd_timer_ctrl #(.DIGITS(4)) dut (
        .CLK(clk), .Clear_b(Clear_b), .tick(tick),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_load(cmd_load), .cmd_clear(cmd_clear),
        .preset(preset), .target(target), .digit_q(digit_q),
        .cnt_load(cnt_load), .cnt_data(cnt_data), .cnt_en(cnt_en), .cnt_clr_b(cnt_clr_b),
        .running(running), .done(done), .wrap(wrap), .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Model of the four cascaded BCD digit counters
    always @(posedge clk) begin
        if (!cnt_clr_b) begin
            digit_q <= '0;
        end else if (cnt_load) begin
            digit_q <= cnt_data;
        end else begin
            for (int i = 0; i < 4; i++)
                if (cnt_en[i])
                    digit_q[4*i +: 4] <= (digit_q[4*i +: 4] == 4'd9) ? 4'd0 : digit_q[4*i +: 4] + 4'd1;
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        preset = v; cmd_load = 1'b1; step(); cmd_load = 1'b0; step();
    endtask

    task automatic do_start();
        cmd_start = 1'b1; step(); cmd_start = 1'b0;
    endtask

    task automatic test_reset();
        Clear_b = 1'b0; tick = 1'b1; cmd_start = 1'b1;
        repeat (3) step();
        n_cmp++; if (cnt_clr_b !== 1'b0) begin n_err++; $display("FAIL reset_clr_b: got %0b want 0", cnt_clr_b); end
        n_cmp++; if (cnt_load !== 1'b0) begin n_err++; $display("FAIL reset_load: got %0b want 0", cnt_load); end
        n_cmp++; if (cnt_en !== 4'b0) begin n_err++; $display("FAIL reset_en: got %b want 0000", cnt_en); end
        n_cmp++; if ({done, wrap, running} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {done, wrap, running}); end
        n_cmp++; if (state_dbg !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); end
        cmd_start = 1'b0; tick = 1'b0; Clear_b = 1'b1;
        step();
        n_cmp++; if (cnt_clr_b !== 1'b1) begin n_err++; $display("FAIL release_clr_b: got %0b want 1", cnt_clr_b); end
        // Reset again, then a clear on the first released edge keeps cnt_clr_b low one more cycle
        Clear_b = 1'b0; step(); step();
        Clear_b = 1'b1; cmd_clear = 1'b1; step(); cmd_clear = 1'b0;
        n_cmp++; if (cnt_clr_b !== 1'b0 || running !== 1'b0) begin n_err++; $display("FAIL clr_cycle: got clr_b=%0b run=%0b want 0 0", cnt_clr_b, running); end
        n_cmp++; if (state_dbg !== ST_CLR) begin n_err++; $display("FAIL clr_state: got %0d want %0d", state_dbg, ST_CLR); end
        step();
        n_cmp++; if (cnt_clr_b !== 1'b1 || running !== 1'b0 || state_dbg !== ST_IDLE) begin n_err++; $display("FAIL after_clr: got clr_b=%0b run=%0b st=%0d want 1 0 0", cnt_clr_b, running, state_dbg); end
    endtask

    task automatic test_load_carry();
        logic [3:0] exp_en;
        target = 16'h9999; preset = 16'h0095; cmd_load = 1'b1; step(); cmd_load = 1'b0;
        n_cmp++; if (cnt_load !== 1'b1 || cnt_data !== 16'h0095) begin n_err++; $display("FAIL load_strobe: got load=%0b data=%h want 1 0095", cnt_load, cnt_data); end
        step();
        n_cmp++; if (cnt_load !== 1'b0 || digit_q !== 16'h0095) begin n_err++; $display("FAIL load_done: got load=%0b digits=%h want 0 0095", cnt_load, digit_q); end
        do_start();
        n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL start_running: got %0b want 1", running); end
        for (int k = 0; k < 10; k++) begin
            tick = 1'b1; #1;
            exp_en = (k == 4) ? 4'b0111 : 4'b0001;
            n_cmp++; if (cnt_en !== exp_en) begin n_err++; $display("FAIL carry_en[%0d]: got %b want %b (digits=%h)", k, cnt_en, exp_en, digit_q); end
            step();
        end
        tick = 1'b0;
        n_cmp++; if (digit_q !== 16'h0105) begin n_err++; $display("FAIL carry_final: got %h want 0105", digit_q); end
        cmd_stop = 1'b1; step(); cmd_stop = 1'b0;
        n_cmp++; if (running !== 1'b0 || state_dbg !== ST_PAUSE) begin n_err++; $display("FAIL stop_pause: got run=%0b st=%0d want 0 %0d", running, state_dbg, ST_PAUSE); end
    endtask

    task automatic test_target_done();
        int done_cnt = 0;
        int done_at = -1;
        target = 16'h0003; do_load(16'h0000); do_start();
        tick = 1'b1;
        for (int s = 1; s <= 8; s++) begin
            step();
            if (done === 1'b1) begin done_cnt++; done_at = s; end
        end
        n_cmp++; if (digit_q !== 16'h0003) begin n_err++; $display("FAIL target_digits: got %h want 0003", digit_q); end
        n_cmp++; if (done_cnt !== 1 || done_at !== 4) begin n_err++; $display("FAIL target_done: got %0d pulses at %0d want 1 at 4", done_cnt, done_at); end
        n_cmp++; if (cnt_en !== 4'b0 || state_dbg !== ST_DONE) begin n_err++; $display("FAIL done_hold: got en=%b st=%0d want 0000 %0d", cnt_en, state_dbg, ST_DONE); end
        cmd_start = 1'b1; step(); cmd_start = 1'b0; step();
        n_cmp++; if (running !== 1'b0 || state_dbg !== ST_DONE || digit_q !== 16'h0003) begin n_err++; $display("FAIL done_ignore_start: got run=%0b st=%0d digits=%h want 0 %0d 0003", running, state_dbg, digit_q, ST_DONE); end
        tick = 1'b0;
    endtask

    task automatic test_wrap();
        int wrap_cnt = 0;
        int wrap_at = -1;
        int done_cnt = 0;
        logic [3:0] en_at_9999 = '0;
        target = 16'h0001; do_load(16'h9998); do_start();
        tick = 1'b1;
        for (int s = 1; s <= 6; s++) begin
            #1;
            if (s == 2) en_at_9999 = cnt_en;
            step();
            if (wrap === 1'b1) begin wrap_cnt++; wrap_at = s; end
            if (done === 1'b1) done_cnt++;
            if (s == 3) begin
                n_cmp++; if (digit_q !== 16'h0001) begin n_err++; $display("FAIL wrap_digits: got %h want 0001", digit_q); end
            end
        end
        tick = 1'b0;
        n_cmp++; if (en_at_9999 !== 4'b1111) begin n_err++; $display("FAIL wrap_en: got %b want 1111", en_at_9999); end
        n_cmp++; if (wrap_cnt !== 1 || wrap_at !== 2) begin n_err++; $display("FAIL wrap_pulse: got %0d pulses at %0d want 1 at 2", wrap_cnt, wrap_at); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL wrap_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_stop_tick();
        target = 16'h9999; do_load(16'h0010); do_start();
        tick = 1'b1; step(); step();
        cmd_stop = 1'b1; #1;
        n_cmp++; if (cnt_en[0] !== 1'b1) begin n_err++; $display("FAIL stop_tick_en: got %0b want 1", cnt_en[0]); end
        step(); cmd_stop = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            n_cmp++; if (cnt_en !== 4'b0 || running !== 1'b0) begin n_err++; $display("FAIL pause_en[%0d]: got en=%b run=%0b want 0000 0", s, cnt_en, running); end
            step();
        end
        n_cmp++; if (digit_q !== 16'h0013) begin n_err++; $display("FAIL pause_digits: got %h want 0013", digit_q); end
        cmd_start = 1'b1; step(); cmd_start = 1'b0;
        n_cmp++; if (digit_q !== 16'h0013 || running !== 1'b1) begin n_err++; $display("FAIL resume: got digits=%h run=%0b want 0013 1", digit_q, running); end
        step();
        cmd_start = 1'b1; step(); cmd_start = 1'b0;
        n_cmp++; if (digit_q !== 16'h0015 || running !== 1'b1) begin n_err++; $display("FAIL start_in_run: got digits=%h run=%0b want 0015 1", digit_q, running); end
        tick = 1'b0;
    endtask

    task automatic test_priority();
        cmd_clear = 1'b1; cmd_stop = 1'b1; step(); cmd_clear = 1'b0; cmd_stop = 1'b0;
        n_cmp++; if (state_dbg !== ST_CLR || cnt_clr_b !== 1'b0) begin n_err++; $display("FAIL prio_clear_run: got st=%0d clr_b=%0b want %0d 0", state_dbg, cnt_clr_b, ST_CLR); end
        step();
        n_cmp++; if (digit_q !== 16'h0000) begin n_err++; $display("FAIL prio_cleared: got %h want 0000", digit_q); end
        cmd_stop = 1'b1; cmd_start = 1'b1; step(); cmd_stop = 1'b0; cmd_start = 1'b0;
        n_cmp++; if (state_dbg !== ST_IDLE) begin n_err++; $display("FAIL prio_stop_start: got %0d want %0d", state_dbg, ST_IDLE); end
        preset = 16'h0042; cmd_clear = 1'b1; cmd_load = 1'b1; step(); cmd_clear = 1'b0; cmd_load = 1'b0;
        n_cmp++; if (state_dbg !== ST_CLR || cnt_load !== 1'b0) begin n_err++; $display("FAIL prio_clear_load: got st=%0d load=%0b want %0d 0", state_dbg, cnt_load, ST_CLR); end
        step();
    endtask

    task automatic test_reset_abort();
        int done_cnt = 0;
        target = 16'h0002; do_load(16'h0000); do_start();
        tick = 1'b1; step();
        Clear_b = 1'b0; step();
        n_cmp++; if (state_dbg !== ST_IDLE || running !== 1'b0 || cnt_clr_b !== 1'b0) begin n_err++; $display("FAIL abort_state: got st=%0d run=%0b clr_b=%0b want 0 0 0", state_dbg, running, cnt_clr_b); end
        Clear_b = 1'b1;
        for (int s = 0; s < 6; s++) begin
            step();
            if (done === 1'b1 || wrap === 1'b1) done_cnt++;
        end
        n_cmp++; if (done_cnt !== 0 || running !== 1'b0) begin n_err++; $display("FAIL abort_no_done: got pulses=%0d run=%0b want 0 0", done_cnt, running); end
        tick = 1'b0;
    endtask

`ifdef BCD_TIMER_AUTORELOAD_EN
    task automatic test_autoreload();
        int done_cnt = 0;
        int reload_ok = 0;
        logic prev_done = 1'b0;
        target = 16'h0002; do_load(16'h0000); do_start();
        tick = 1'b1;
        for (int s = 1; s <= 20; s++) begin
            step();
            if (prev_done && cnt_load === 1'b1) reload_ok++;
            if (done === 1'b1) done_cnt++;
            prev_done = (done === 1'b1);
        end
        n_cmp++; if (done_cnt !== 4 || reload_ok !== 4) begin n_err++; $display("FAIL autoreload: got done=%0d reloads=%0d want 4 4", done_cnt, reload_ok); end
        Clear_b = 1'b0; step(); Clear_b = 1'b1;
        done_cnt = 0;
        for (int s = 0; s < 4; s++) begin
            if (done === 1'b1) done_cnt++;
            step();
        end
        n_cmp++; if (done_cnt !== 0 || state_dbg !== ST_IDLE) begin n_err++; $display("FAIL autoreload_reset: got done=%0d st=%0d want 0 %0d", done_cnt, state_dbg, ST_IDLE); end
        tick = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_load_carry();
`ifdef BCD_TIMER_AUTORELOAD_EN
        test_autoreload();
`else
        test_target_done();
`endif
        test_wrap();
        test_stop_tick();
        test_priority();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
